// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: segment encoding constants shared by the scan driver and its decoder
package seg_pkg;
  localparam int SEG_A = 7;
  localparam int SEG_DP = 0;
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: user-side load port and frame strobe of the scan driver
interface seg_scan_driver_if #(parameter int DIGITS = 8);
  logic load;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] dp_mask, blank_mask, blink_mask;
  logic lz_en;
  logic frame_done;
  modport master(output load, value, dp_mask, blank_mask, blink_mask, lz_en, input frame_done);
  modport slave(input load, value, dp_mask, blank_mask, blink_mask, lz_en, output frame_done);
endinterface

// File: rtl/seg_scan_driver_decoder.sv
// seg_decoder: nibble + dp + dark to active-high segment pattern
module seg_decoder
  import seg_pkg::*;
(
    input  logic              nib_dark,
    input  logic [3:0]        nib,
    input  logic              dp,
    output logic [SEG_A:SEG_DP] seg
);
    always_comb seg = nib_dark ? SEG_OFF : SEG_TABLE[nib] | (8'(dp) << SEG_DP);
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered, time-multiplexed seven-segment scanner
module seg_scan_driver
  import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 50000,
    parameter int GUARD        = 1,
    parameter int BLINK_FRAMES = 64,
    parameter bit ACTIVE_LOW   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg_scan_driver_if.slave     bus,
    output logic [7:0]           seg_out,
    output logic [DIGITS-1:0]    an_out
);
    localparam int PW = $clog2(PRESCALE);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam int CW = 7 * DIGITS + 1;
    // buffer layout {lz_en, blink, blank, dp, value}; reset blanks every digit
    localparam logic [CW-1:0] AC_RST = {1'b0, {DIGITS{1'b0}}, {DIGITS{1'b1}}, {5*DIGITS{1'b0}}};

    logic [PW-1:0]       pcnt;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       bcnt;
    logic                phase, pending, run, dark, slot_end, frame_end, blink_wrap;
    logic [CW-1:0]       sh, ac, in_buf;
    logic [4*DIGITS-1:0] ac_val;
    logic [DIGITS-1:0]   ac_dp, ac_blank, ac_blink, lz_dark, an_c, an_q;
    logic [7:0]          seg_c, seg_q;

    assign in_buf     = {bus.lz_en, bus.blink_mask, bus.blank_mask, bus.dp_mask, bus.value};
    assign ac_val     = ac[4*DIGITS-1:0];
    assign ac_dp      = ac[5*DIGITS-1:4*DIGITS];
    assign ac_blank   = ac[6*DIGITS-1:5*DIGITS];
    assign ac_blink   = ac[7*DIGITS-1:6*DIGITS];
    assign slot_end   = pcnt == PW'(PRESCALE - 1);
    assign frame_end  = slot_end && idx == IW'(DIGITS - 1);
    assign blink_wrap = bcnt == BW'(BLINK_FRAMES - 1);
    assign bus.frame_done = frame_end;

    always_comb begin
        lz_dark = '0;
        run = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            run = run & (ac_val[4*k +: 4] == 4'h0);
            lz_dark[k] = run;
        end
        dark = ac_blank[idx] | (ac_blink[idx] & phase) | (ac[7*DIGITS] & lz_dark[idx]);
        an_c = (dark || int'(pcnt) < GUARD) ? '0 : DIGITS'(1) << idx;
    end

    seg_decoder u_dec (
        .nib_dark(dark),
        .nib     (ac_val[{idx, 2'b00} +: 4]),
        .dp      (ac_dp[idx]),
        .seg     (seg_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= '0;
            idx     <= '0;
            bcnt    <= '0;
            phase   <= 1'b0;
            pending <= 1'b0;
            sh      <= '0;
            ac      <= AC_RST;
            seg_q   <= SEG_OFF;
            an_q    <= '0;
        end else begin
            pcnt <= slot_end ? '0 : pcnt + 1'b1;
            if (slot_end) idx <= frame_end ? '0 : idx + 1'b1;
            if (frame_end) begin
                bcnt  <= blink_wrap ? '0 : bcnt + 1'b1;
                phase <= phase ^ blink_wrap;
            end
            if (bus.load) sh <= in_buf;
            // a load landing on the boundary edge bypasses the shadow
            if (frame_end) ac <= bus.load ? in_buf : pending ? sh : ac;
            pending <= frame_end ? 1'b0 : pending | bus.load;
            seg_q   <= seg_c;
            an_q    <= an_c;
        end
    end

    assign seg_out = ACTIVE_LOW ? ~seg_q : seg_q;
    assign an_out  = ACTIVE_LOW ? ~an_q : an_q;
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver. It captures a packed hexadecimal value with per-digit decimal-point, blank and blink masks into a shadow buffer. It commits the buffer to the display only at frame boundaries, so the display never tears. It then scans the digits one at a time onto a shared segment bus and one-hot anode lines, and sits between user logic and the board's multiplexed LED digits.

## Interface
- DIGITS, 8: number of digits scanned (1..16); digit 0 is rightmost/least significant.
- PRESCALE, 50000: clocks per digit slot (≥2).
- GUARD, 1: clocks at slot start with all anodes off (0 disables; < PRESCALE).
- BLINK_FRAMES, 64: frames per blink half-period (≥1).
- ACTIVE_LOW, 1: 1 inverts seg_out and an_out at the pins.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle strobe; captures value and masks.
- value  input  4*DIGITS  nibble i = digit i.
- dp_mask  input  DIGITS  1 = decimal point lit.
- blank_mask  input  DIGITS  1 = digit dark.
- blink_mask  input  DIGITS  1 = digit blinks.
- lz_en  input  1  leading-zero suppression, sampled with load.
- seg_out  output  8  segments {a,b,c,d,e,f,g,dp}, MSB = a.
- an_out  output  DIGITS  one-hot anode select.
- frame_done  output  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler pcnt counts 0..PRESCALE-1. At its terminal count, digit index idx advances, wrapping DIGITS-1 → 0.
- Frame boundary means the edge where idx wraps to 0. At that edge:
  - frame_done pulses.
  - The blink frame counter increments. On reaching BLINK_FRAMES it clears and toggles blink_phase.
- Load handling:
  - load writes shadow registers and sets pending. A load while pending overwrites the shadow; the last load wins.
  - At a boundary with pending=1, shadow is copied to active and pending clears.
  - If load is high on the boundary edge itself, the load data goes directly to active and pending stays 0.
- Active-high segment codes for nibbles 0..F: FC 60 DA F2 66 B6 BE E0 FE F6 EE 3E 9C 7A 9E 8E. dp is OR'd into bit 0.
- Digit i is dark (anode off, segments off, dp off) when any of these holds:
  - blank_mask[i] is set.
  - blink_mask[i] is set and blink_phase=1.
  - lz_en is set, i≠0, and nibbles i..DIGITS-1 are all zero.
- Digit 0 is never suppressed, so value 0 displays "0".
- Anode for idx is asserted except during pcnt < GUARD or when the digit is dark.
- Polarity: when ACTIVE_LOW=1, both outputs are the bitwise inverse of the active-high values.

## Timing
- Reset (asynchronous, immediate):
  - pcnt=0, idx=0, blink counter 0, blink_phase=0, pending=0.
  - Shadow and active cleared, with active blank mask all-ones, so the display stays dark until the first load commits.
  - seg_out and an_out read all-off (8'hFF and all-ones for ACTIVE_LOW=1); frame_done=0.
- seg_out and an_out are registered: they reflect idx/pcnt one clock after those registers update.
- Load-to-visible latency runs from 1 clock (load on the boundary edge) to DIGITS·PRESCALE clocks, plus the 1-cycle output register.
- frame_done is high for exactly one clock per DIGITS·PRESCALE clocks.
- Deasserting rst_n mid-scan restarts at digit 0 slot 0 on the first clock edge after release, with no partial frame_done.

## Structure
- Package seg_pkg holds:
  - The 16×8 hex-to-segment constant table.
  - SEG_OFF (8'h00 active-high).
  - Segment bit-position constants.
- One combinational sub-module, seg_decoder, maps nibble + dp + dark to 8-bit active-high segments. The top level holds the prescaler, scan/blink counters, shadow/active buffers and output registers.

## Test plan
Settings: DIGITS=4, PRESCALE=4, GUARD=1, BLINK_FRAMES=2, ACTIVE_LOW=1.
- Reset: assert rst_n=0 mid-slot → seg_out=8'hFF, an_out=4'hF, frame_done=0 in the same cycle; no anode asserted until after the first load commits.
- Basic scan: load 16'h1A2F, masks 0, lz_en=0 → next frame:
  - digit0: seg_out=8'h71, an_out=4'b1110.
  - digit1: seg_out=8'h25.
  - digit2: seg_out=8'h11.
  - digit3: seg_out=8'h9F, an_out=4'b0111.
  - The anode is off for the first cycle of every slot.
- Leading zeros: load 16'h0005, lz_en=1 → only digit0 anode ever asserts (seg 8'h49). Load 16'h0000 → digit0 shows 8'h03.
- Double buffering: load A mid-frame, then load B in the same frame → old data persists until frame_done, then B is displayed (A never appears). A load coincident with frame_done is visible in that next frame.
- Blink: blink_mask=4'b0010, dp_mask=4'b0001 → digit1 visible in frames 0–1, dark in frames 2–3, visible in frames 4–5. Digit0 segment bit 0 stays low (dp lit) throughout.
- Blank and guard: blank_mask=4'b1000 → an_out[3] never asserts. Across 3 frames, frame_done pulses exactly every 16 clocks.
